// File: rtl/fpu_issue_seq_pkg.sv
// Shared FPU op codes, sequencer state encoding and default widths.
package fpu_issue_seq_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned REG_W_DEF = 5;
  localparam int unsigned OP_W      = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_MUL     = 3'b010,
    OP_DIV     = 3'b011,
    OP_SQRT    = 3'b100,
    OP_FCVT_LD = 3'b101,
    OP_FCVT_DL = 3'b110,
    OP_ILLEGAL = 3'b111
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_issue_seq_wdog.sv
// EXEC watchdog: saturating cycle counter with clear, enable and expiry flag.
module fpu_issue_seq_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  assign expired_c = (count == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fpu_issue_seq.sv
// Single-op FPU issue sequencer: accept, start unit, wait for done, hold writeback.
// Optional EXEC watchdog enabled by defining FPU_TIMEOUT_EN.
module fpu_issue_seq
  import fpu_issue_seq_pkg::*;
#(
  parameter int unsigned XLEN           = XLEN_DEF,
  parameter int unsigned REG_W          = REG_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [REG_W-1:0] in_rd,
  output logic             unit_start,
  output logic [2:0]       unit_sel,
  output logic [XLEN-1:0]  unit_a,
  output logic [XLEN-1:0]  unit_b,
  input  logic             unit_done,
  input  logic [XLEN-1:0]  unit_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [XLEN-1:0]  wb_data,
  output logic [REG_W-1:0] wb_rd,
  output logic             wb_int,
  output logic             wb_illegal,
  output logic             wb_timeout
);

  state_e           state_q, state_d;
  logic             start_d;
  logic [2:0]       sel_d;
  logic [XLEN-1:0]  a_d, b_d, data_d;
  logic [REG_W-1:0] rd_d;
  logic             int_d, ill_d;
  logic             wdog_clr;

`ifdef FPU_TIMEOUT_EN
  logic expired_c;
  logic to_d;

  fpu_issue_seq_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (wdog_clr),
    .en        (state_q == ST_EXEC),
    .expired_c (expired_c)
  );
`else
  assign wb_timeout = 1'b0;
`endif

  // Next state and next register values
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    sel_d    = unit_sel;
    a_d      = unit_a;
    b_d      = unit_b;
    rd_d     = wb_rd;
    data_d   = wb_data;
    int_d    = wb_int;
    ill_d    = wb_illegal;
    wdog_clr = 1'b0;
`ifdef FPU_TIMEOUT_EN
    to_d     = wb_timeout;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sel_d = in_op;
          a_d   = in_rs1;
          b_d   = in_rs2;
          rd_d  = in_rd;
          int_d = (in_op == OP_FCVT_LD);
          if (in_op == OP_ILLEGAL) begin
            state_d = ST_WB;
            ill_d   = 1'b1;
            data_d  = '0;
          end else begin
            state_d  = ST_EXEC;
            start_d  = 1'b1;
            wdog_clr = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        // done takes priority over a same-cycle watchdog expiry
        if (unit_done) begin
          state_d = ST_WB;
          data_d  = unit_result;
`ifdef FPU_TIMEOUT_EN
        end else if (expired_c) begin
          state_d = ST_WB;
          data_d  = '0;
          to_d    = 1'b1;
`endif
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          state_d = ST_IDLE;
          int_d   = 1'b0;
          ill_d   = 1'b0;
`ifdef FPU_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready   <= 1'b1;
      unit_start <= 1'b0;
      unit_sel   <= '0;
      unit_a     <= '0;
      unit_b     <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      wb_int     <= 1'b0;
      wb_illegal <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready   <= (state_d == ST_IDLE);
      unit_start <= start_d;
      unit_sel   <= sel_d;
      unit_a     <= a_d;
      unit_b     <= b_d;
      wb_valid   <= (state_d == ST_WB);
      wb_data    <= data_d;
      wb_rd      <= rd_d;
      wb_int     <= int_d;
      wb_illegal <= ill_d;
    end
  end

`ifdef FPU_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_timeout <= 1'b0;
    end else begin
      wb_timeout <= to_d;
    end
  end
`endif

endmodule
